// File: rtl/sram_wb_rmw_ctrl.sv
// Wishbone classic slave for a 1W/1R SRAM macro: base-address decode, bus error on bad
// addresses, and byte-lane writes via an internal read-modify-write sequence.
module sram_wb_rmw_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          RD_LAT     = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    sram_csb0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  output logic                    sram_csb1,
  output logic [ADDR_WIDTH-1:0]   sram_addr1,
  input  logic [DATA_WIDTH-1:0]   sram_dout1
);

  localparam int          SEL_W    = DATA_WIDTH / 8;
  localparam int          CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAPT,
    S_WR,
    S_ACK,
    S_ERR
  } state_t;

  state_t state, next;

  logic                  req;
  logic                  in_range;
  logic                  misaligned;
  logic [ADDR_WIDTH+1:0] adr_off;
  logic [ADDR_WIDTH-1:0] adr_idx;
  logic                  sel_full;
  logic                  sel_none;
  logic                  cap_fire;

  logic                  req_we;
  logic [SEL_W-1:0]      req_sel;
  logic [DATA_WIDTH-1:0] req_dat;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rdata;

  // Replace the selected byte lanes of the SRAM word with the bus write data.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] wdat,
    input logic [DATA_WIDTH-1:0] rdat,
    input logic [SEL_W-1:0]      sel
  );
    logic [DATA_WIDTH-1:0] m;
    m = rdat;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) m[8*i +: 8] = wdat[8*i +: 8];
    end
    return m;
  endfunction

  // BASE_ADDR is aligned to the window size, so the in-window offset is just the low bits.
  assign req        = wbs_cyc_i & wbs_stb_i;
  assign adr_off    = wbs_adr_i[ADDR_WIDTH+1:0];
  assign adr_idx    = adr_off[ADDR_WIDTH+1:2];
  assign misaligned = |adr_off[1:0];
  assign in_range   = (wbs_adr_i >= BASE_ADDR) && ({1'b0, wbs_adr_i} < LIMIT);
  assign sel_full   = &wbs_sel_i;
  assign sel_none   = ~|wbs_sel_i;
  assign cap_fire   = (state == S_CAPT) && wbs_cyc_i && (cnt == '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (misaligned || !in_range)  next = S_ERR;
          else if (wbs_we_i && sel_none) next = S_ACK;
          else if (wbs_we_i && sel_full) next = S_WR;
          else                           next = S_RD;
        end
      end
      S_RD:   next = wbs_cyc_i ? S_CAPT : S_IDLE;
      S_CAPT: begin
        if (!wbs_cyc_i)      next = S_IDLE;
        else if (cnt == '0) next = req_we ? S_WR : S_ACK;
      end
      // A write that reached WR always commits; only the ack is dropped on abort.
      S_WR:   next = wbs_cyc_i ? S_ACK : S_IDLE;
      S_ACK:  next = S_IDLE;
      S_ERR:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      req_we     <= 1'b0;
      req_sel    <= '0;
      req_dat    <= '0;
      req_idx    <= '0;
      cnt        <= '0;
      rdata      <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      sram_csb0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      sram_csb1  <= 1'b1;
      sram_addr1 <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        req_we  <= wbs_we_i;
        req_sel <= wbs_sel_i;
        req_dat <= wbs_dat_i;
        req_idx <= adr_idx;
      end

      if (state == S_RD)                      cnt <= CNT_INIT;
      else if (state == S_CAPT && cnt != '0) cnt <= cnt - 1'b1;

      if (cap_fire) rdata <= sram_dout1;

      // SRAM strobes are registered from the next state so they align with RD/WR.
      sram_csb1 <= (next != S_RD);
      if (next == S_RD) sram_addr1 <= adr_idx;

      sram_csb0 <= (next != S_WR);
      if (next == S_WR) begin
        if (state == S_IDLE) begin
          sram_addr0 <= adr_idx;
          sram_din0  <= wbs_dat_i;
        end else begin
          sram_addr0 <= req_idx;
          sram_din0  <= merge_lanes(req_dat, sram_dout1, req_sel);
        end
      end

      wbs_ack_o <= (next == S_ACK);
      wbs_err_o <= (next == S_ERR);
    end
  end

  assign wbs_dat_o = (wbs_ack_o && !req_we) ? rdata : '0;

endmodule

// File: tb/tb_sram_wb_rmw_ctrl.sv
// Directed bench for sram_wb_rmw_ctrl: one instance with RD_LAT=1 and one with RD_LAT=3,
// each backed by a behavioural 1W/1R SRAM with the matching read latency.
module tb_sram_wb_rmw_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] BAD  = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cyc_a, stb_a, we_a, ack_a, err_a, csb0_a, csb1_a;
  logic [3:0]  sel_a;
  logic [31:0] adr_a, dat_a, dato_a, din0_a, dout_a;
  logic [9:0]  addr0_a, addr1_a;

  logic        cyc_b, stb_b, we_b, ack_b, err_b, csb0_b, csb1_b;
  logic [3:0]  sel_b;
  logic [31:0] adr_b, dat_b, dato_b, din0_b;
  logic [9:0]  addr0_b, addr1_b;
  logic [31:0] pb0, pb1, pb2;

  sram_wb_rmw_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BASE_ADDR(BASE), .RD_LAT(1)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc_a), .wbs_stb_i(stb_a), .wbs_we_i(we_a), .wbs_sel_i(sel_a),
    .wbs_adr_i(adr_a), .wbs_dat_i(dat_a),
    .wbs_ack_o(ack_a), .wbs_err_o(err_a), .wbs_dat_o(dato_a),
    .sram_csb0(csb0_a), .sram_addr0(addr0_a), .sram_din0(din0_a),
    .sram_csb1(csb1_a), .sram_addr1(addr1_a), .sram_dout1(dout_a)
  );

  sram_wb_rmw_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BASE_ADDR(BASE), .RD_LAT(3)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc_b), .wbs_stb_i(stb_b), .wbs_we_i(we_b), .wbs_sel_i(sel_b),
    .wbs_adr_i(adr_b), .wbs_dat_i(dat_b),
    .wbs_ack_o(ack_b), .wbs_err_o(err_b), .wbs_dat_o(dato_b),
    .sram_csb0(csb0_b), .sram_addr0(addr0_b), .sram_din0(din0_b),
    .sram_csb1(csb1_b), .sram_addr1(addr1_b), .sram_dout1(pb2)
  );

  // Behavioural SRAMs; an unselected read returns a marker so mistimed captures show up.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  always @(posedge clk) begin
    if (!csb0_a) mem_a[addr0_a] <= din0_a;
    dout_a <= !csb1_a ? mem_a[addr1_a] : BAD;
    if (!csb0_b) mem_b[addr0_b] <= din0_b;
    pb0 <= !csb1_b ? mem_b[addr1_b] : BAD;
    pb1 <= pb0;
    pb2 <= pb1;
  end

  logic        use_b;
  logic        m_ack, m_err, m_csb0, m_csb1;
  logic [31:0] m_dat, m_din0;
  logic [9:0]  m_addr0, m_addr1;
  assign m_ack   = use_b ? ack_b   : ack_a;
  assign m_err   = use_b ? err_b   : err_a;
  assign m_csb0  = use_b ? csb0_b  : csb0_a;
  assign m_csb1  = use_b ? csb1_b  : csb1_a;
  assign m_dat   = use_b ? dato_b  : dato_a;
  assign m_din0  = use_b ? din0_b  : din0_a;
  assign m_addr0 = use_b ? addr0_b : addr0_a;
  assign m_addr1 = use_b ? addr1_b : addr1_a;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic on, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (use_b) begin
      cyc_b = on; stb_b = on; we_b = we; sel_b = sel; adr_b = adr; dat_b = dat;
    end else begin
      cyc_a = on; stb_a = on; we_a = we; sel_a = sel; adr_a = adr; dat_a = dat;
    end
  endtask

  int          lat, n0, n1, t0, t1, stray;
  logic        e;
  logic [9:0]  a0, a1;
  logic [31:0] d0, rd;

  // One bus transaction with a bounded wait; records strobe activity and the ack/err cycle.
  task automatic do_req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat);
    lat = 0; e = 1'b0; n0 = 0; n1 = 0; t0 = 0; t1 = 0; stray = 0;
    a0 = '0; a1 = '0; d0 = '0; rd = '0;
    @(negedge clk);
    drive(1'b1, we, sel, adr, dat);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!m_csb0) begin n0++; if (t0 == 0) t0 = c; a0 = m_addr0; d0 = m_din0; end
      if (!m_csb1) begin n1++; if (t1 == 0) t1 = c; a1 = m_addr1; end
      if (!m_csb0 && !m_csb1) stray++;
      if (m_ack && m_err) stray++;
      if (!m_ack && m_dat != 0) stray++;
      if (m_ack || m_err) begin lat = c; e = m_err; rd = m_dat; break; end
    end
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    if (m_ack || m_err || m_dat != 0 || !m_csb0 || !m_csb1) stray++;
  endtask

  logic [31:0] eadr [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    use_b = 1'b0;
    rst = 1'b1;
    cyc_a = 0; stb_a = 0; we_a = 0; sel_a = 0; adr_a = 0; dat_a = 0;
    cyc_b = 0; stb_b = 0; we_b = 0; sel_b = 0; adr_b = 0; dat_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, ack_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_csb", {30'd0, csb0_a, csb1_a}, 32'd3);
    chk("rst_dat", dato_a, 32'h0);
    chk("rst_din0", din0_a, 32'h0);
    chk("rst_addr", {12'd0, addr0_a, addr1_a}, 32'h0);
    rst = 1'b0;

    // Full write then read
    do_req(1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
    chk("fw_lat", lat, 2);
    chk("fw_csb0", n0, 1);
    chk("fw_csb1", n1, 0);
    chk("fw_addr0", {22'd0, a0}, 32'd4);
    chk("fw_din0", d0, 32'hDEADBEEF);
    chk("fw_stray", stray, 0);
    do_req(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    chk("rd_lat", lat, 3);
    chk("rd_csb1", n1, 1);
    chk("rd_addr1", {22'd0, a1}, 32'd4);
    chk("rd_csb0", n0, 0);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_stray", stray, 0);

    // Partial write: read pulse first, then merged write
    do_req(1'b1, 4'b0010, BASE + 32'h10, 32'h0000AA00);
    chk("pw_lat", lat, 4);
    chk("pw_t1", t1, 1);
    chk("pw_t0", t0, 3);
    chk("pw_cnt", {n0[15:0], n1[15:0]}, 32'h0001_0001);
    chk("pw_din0", d0, 32'hDEADAAEF);
    chk("pw_addr0", {22'd0, a0}, 32'd4);
    chk("pw_stray", stray, 0);
    do_req(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    chk("pw_rdback", rd, 32'hDEADAAEF);

    // Address errors
    eadr[0] = BASE + 32'h1000;
    eadr[1] = BASE + 32'h2;
    eadr[2] = BASE - 32'h4;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 4'hF, eadr[i], 32'h0);
      chk($sformatf("err%0d_lat", i), lat, 1);
      chk($sformatf("err%0d_flag", i), {31'd0, e}, 32'd1);
      chk($sformatf("err%0d_sram", i), n0 + n1, 0);
      chk($sformatf("err%0d_stray", i), stray, 0);
    end
    do_req(1'b1, 4'hF, BASE + 32'hFFC, 32'hCAFEF00D);
    chk("top_wr_lat", lat, 2);
    chk("top_wr_err", {31'd0, e}, 32'd0);
    chk("top_addr0", {22'd0, a0}, 32'h3FF);
    do_req(1'b0, 4'hF, BASE + 32'hFFC, 32'h0);
    chk("top_rd_lat", lat, 3);
    chk("top_rd_data", rd, 32'hCAFEF00D);

    // Empty select write
    do_req(1'b1, 4'h0, BASE + 32'h10, 32'hFFFFFFFF);
    chk("sel0_lat", lat, 1);
    chk("sel0_err", {31'd0, e}, 32'd0);
    chk("sel0_sram", n0 + n1, 0);
    do_req(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    chk("sel0_rdback", rd, 32'hDEADAAEF);

    // Abort a read in CAPT
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, BASE + 32'h10, 32'h0);
    @(negedge clk);
    chk("ab_rd_csb1", {31'd0, csb1_a}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ab_ack0", {30'd0, ack_a, err_a}, 32'd0);
    @(negedge clk);
    chk("ab_ack1", {29'd0, ack_a, err_a, csb0_a}, 32'd1);
    do_req(1'b0, 4'hF, BASE + 32'hFFC, 32'h0);
    chk("ab_next_lat", lat, 3);
    chk("ab_next_data", rd, 32'hCAFEF00D);

    // Abort during WR: write still commits, no ack
    @(negedge clk);
    drive(1'b1, 1'b1, 4'hF, BASE + 32'h20, 32'h11111111);
    @(negedge clk);
    chk("abwr_csb0", {31'd0, csb0_a}, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("abwr_noack", {30'd0, ack_a, err_a}, 32'd0);
    do_req(1'b0, 4'hF, BASE + 32'h20, 32'h0);
    chk("abwr_rdback", rd, 32'h11111111);

    // Reset asserted during WR
    @(negedge clk);
    drive(1'b1, 1'b1, 4'hF, BASE + 32'h20, 32'h55555555);
    @(negedge clk);
    chk("rstwr_csb0_pre", {31'd0, csb0_a}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rstwr_csb0", {31'd0, csb0_a}, 32'd1);
    chk("rstwr_ack", {31'd0, ack_a}, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 4'hF, BASE + 32'h20, 32'h0);
    chk("rstwr_rdback", rd, 32'h11111111);

    // RD_LAT=3 instance
    use_b = 1'b1;
    do_req(1'b1, 4'hF, BASE + 32'h20, 32'h12345678);
    chk("l3_wr_lat", lat, 2);
    do_req(1'b0, 4'hF, BASE + 32'h20, 32'h0);
    chk("l3_rd_lat", lat, 5);
    chk("l3_rd_data", rd, 32'h12345678);
    chk("l3_rd_stray", stray, 0);
    do_req(1'b1, 4'b1001, BASE + 32'h20, 32'hAA0000BB);
    chk("l3_pw_lat", lat, 6);
    chk("l3_pw_din0", d0, 32'hAA3456BB);
    do_req(1'b0, 4'hF, BASE + 32'h20, 32'h0);
    chk("l3_pw_rdback", rd, 32'hAA3456BB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
